// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: MDU freeze, branch flush, load-use stall and operand forwarding.
// Define HAZARD_STATS_EN to add the saturating StallCnt/FlushCnt statistics outputs.
module hazard_ctl #(
   parameter int unsigned MDU_LAT = 4,
   parameter int unsigned CNT_W   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs_ID,
   input  logic [4:0] Rt_ID,
   input  logic       UsesRs_ID,
   input  logic       UsesRt_ID,
   input  logic [4:0] WriteReg_EX,
   input  logic       RegWrite_EX,
   input  logic       MemToReg_EX,
   input  logic [4:0] WriteReg_ME,
   input  logic       RegWrite_ME,
   input  logic       MduStart_EX,
   input  logic       BranchTaken_EX,
   output logic       AnyStall,
   output logic       StallFront,
   output logic       Flush_ID,
   output logic       Flush_EX,
   output logic [1:0] FwdA_ID,
   output logic [1:0] FwdB_ID,
   output logic       Busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] StallCnt,
   output logic [15:0] FlushCnt
`endif
);

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StMduBusy = 1'b1;

   localparam logic [CNT_W-1:0] LatM1 = CNT_W'(MDU_LAT - 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic idle, busy, mdu_stall, branch_flush, load_hit, load_use;

   always_comb begin
      idle         = (state_q == StIdle);
      busy         = (state_q == StMduBusy);
      mdu_stall    = busy | (idle & MduStart_EX);
      branch_flush = idle & ~MduStart_EX & BranchTaken_EX;
      load_hit     = RegWrite_EX & MemToReg_EX & (WriteReg_EX != 5'd0) &
                     ((UsesRs_ID & (Rs_ID == WriteReg_EX)) |
                      (UsesRt_ID & (Rt_ID == WriteReg_EX)));
      // Branch squashes the wrong-path instruction, so its load-use is moot.
      load_use     = idle & ~MduStart_EX & ~BranchTaken_EX & load_hit;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (idle) begin
         if (MduStart_EX && (MDU_LAT > 1)) begin
            state_d = StMduBusy;
            cnt_d   = LatM1;
         end
      end else begin
         if (cnt_q == CNT_W'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      logic [1:0] sel;
      sel = 2'b00;
      if (RegWrite_EX && !MemToReg_EX && (WriteReg_EX != 5'd0) && (src == WriteReg_EX)) begin
         sel = 2'b10;
      end else if (RegWrite_ME && (WriteReg_ME != 5'd0) && (src == WriteReg_ME)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Outputs are gated by reset so they read zero for the whole reset assertion.
   always_comb begin
      AnyStall   = ~reset & mdu_stall;
      StallFront = ~reset & load_use;
      Flush_ID   = ~reset & branch_flush;
      Flush_EX   = ~reset & (branch_flush | load_use);
      Busy       = ~reset & busy;
      FwdA_ID    = reset ? 2'b00 : fwd_sel(Rs_ID);
      FwdB_ID    = reset ? 2'b00 : fwd_sel(Rt_ID);
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((AnyStall | StallFront) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (Flush_ID && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: expectations queued per step, popped and asserted mid-cycle.
module tb_hazard_ctl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs_ID, Rt_ID, WriteReg_EX, WriteReg_ME;
   logic       UsesRs_ID, UsesRt_ID, RegWrite_EX, MemToReg_EX, RegWrite_ME;
   logic       MduStart_EX, BranchTaken_EX;
   logic       AnyStall, StallFront, Flush_ID, Flush_EX, Busy;
   logic [1:0] FwdA_ID, FwdB_ID;
`ifdef HAZARD_STATS_EN
   logic [15:0] StallCnt, FlushCnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [8:0] vec;
   } exp_t;
   exp_t sb[$];

   hazard_ctl #(.MDU_LAT(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
      .WriteReg_EX(WriteReg_EX), .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX),
      .WriteReg_ME(WriteReg_ME), .RegWrite_ME(RegWrite_ME),
      .MduStart_EX(MduStart_EX), .BranchTaken_EX(BranchTaken_EX),
      .AnyStall(AnyStall), .StallFront(StallFront), .Flush_ID(Flush_ID),
      .Flush_EX(Flush_EX), .FwdA_ID(FwdA_ID), .FwdB_ID(FwdB_ID), .Busy(Busy)
`ifdef HAZARD_STATS_EN
      , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
   );

   always #5 clk = ~clk;

   // Vector layout: {AnyStall, StallFront, Flush_ID, Flush_EX, FwdA[1:0], FwdB[1:0], Busy}
   function automatic logic [8:0] obs();
      return {AnyStall, StallFront, Flush_ID, Flush_EX, FwdA_ID, FwdB_ID, Busy};
   endfunction

   task automatic clear_in();
      Rs_ID = 0; Rt_ID = 0; UsesRs_ID = 0; UsesRt_ID = 0;
      WriteReg_EX = 0; RegWrite_EX = 0; MemToReg_EX = 0;
      WriteReg_ME = 0; RegWrite_ME = 0; MduStart_EX = 0; BranchTaken_EX = 0;
   endtask

   task automatic set_load_use();
      RegWrite_EX = 1; MemToReg_EX = 1; WriteReg_EX = 5; Rs_ID = 5; UsesRs_ID = 1;
   endtask

   task automatic check_now();
      exp_t e;
      logic [8:0] o;
      e = sb.pop_front();
      o = obs();
      checks++;
      assert (o === e.vec) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", e.tag, o, e.vec);
      end
   endtask

   // Called just after a negedge with inputs already driven; samples before the posedge.
   task automatic step(input string tag, input logic [8:0] v);
      sb.push_back('{tag, v});
      #2;
      check_now();
   endtask

   task automatic cnt_check(input string tag, input logic [15:0] o, input logic [15:0] x);
      checks++;
      assert (o === x) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, x);
      end
   endtask

   initial begin
      clear_in();
      reset = 1;
      // Inputs that would otherwise forward and stall must be masked by reset.
      set_load_use(); RegWrite_ME = 1; WriteReg_ME = 5; MduStart_EX = 1;
      #3;
      step("reset_gating", 9'b0_0_0_0_00_00_0);
      @(negedge clk); clear_in(); reset = 0;
      step("idle_after_reset", 9'b0_0_0_0_00_00_0);

      @(negedge clk); clear_in(); set_load_use();
      step("load_use", 9'b0_1_0_1_00_00_0);
      @(negedge clk); clear_in(); Rs_ID = 5; UsesRs_ID = 1; RegWrite_ME = 1; WriteReg_ME = 5;
      step("load_fwd_me", 9'b0_0_0_0_01_00_0);

      @(negedge clk); clear_in(); RegWrite_EX = 1; WriteReg_EX = 7;
      RegWrite_ME = 1; WriteReg_ME = 7; Rt_ID = 7; UsesRt_ID = 1; Rs_ID = 3;
      step("fwd_ex_priority", 9'b0_0_0_0_00_10_0);
      @(negedge clk); WriteReg_EX = 0; Rt_ID = 0;
      step("fwd_r0_ex", 9'b0_0_0_0_00_00_0);
      @(negedge clk); clear_in(); RegWrite_ME = 1; WriteReg_ME = 0; Rs_ID = 0; Rt_ID = 0;
      step("fwd_r0_me", 9'b0_0_0_0_00_00_0);
      @(negedge clk); clear_in(); RegWrite_ME = 1; WriteReg_ME = 9; Rs_ID = 9; Rt_ID = 9;
      step("fwd_me_both", 9'b0_0_0_0_01_01_0);

      @(negedge clk); clear_in(); set_load_use(); BranchTaken_EX = 1;
      step("branch_over_loaduse", 9'b0_0_1_1_00_00_0);

      // MDU op: 4 stall cycles, branch and load-use ignored while busy.
      @(negedge clk); clear_in(); MduStart_EX = 1;
      step("mdu_c1", 9'b1_0_0_0_00_00_0);
      @(negedge clk); clear_in();
      step("mdu_c2", 9'b1_0_0_0_00_00_1);
      @(negedge clk); BranchTaken_EX = 1;
      step("mdu_c3_branch", 9'b1_0_0_0_00_00_1);
      @(negedge clk); clear_in(); set_load_use();
      step("mdu_c4_loaduse", 9'b1_0_0_0_00_00_1);
      @(negedge clk); clear_in();
      step("mdu_done", 9'b0_0_0_0_00_00_0);

      // Back-to-back: MduStart held high; reread only in the first IDLE cycle.
      @(negedge clk); MduStart_EX = 1;
      step("b2b_a1", 9'b1_0_0_0_00_00_0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         step("b2b_a_busy", 9'b1_0_0_0_00_00_1);
      end
      @(negedge clk);
      step("b2b_b1", 9'b1_0_0_0_00_00_0);
      @(negedge clk); MduStart_EX = 0;
      step("b2b_b2", 9'b1_0_0_0_00_00_1);
      @(negedge clk);
      step("b2b_b3", 9'b1_0_0_0_00_00_1);
      @(negedge clk);
      step("b2b_b4", 9'b1_0_0_0_00_00_1);
      @(negedge clk);
      step("b2b_done", 9'b0_0_0_0_00_00_0);

      // Asynchronous reset in stall cycle 2.
      @(negedge clk); MduStart_EX = 1;
      step("rst_mdu_c1", 9'b1_0_0_0_00_00_0);
      @(negedge clk); MduStart_EX = 0; RegWrite_ME = 1; WriteReg_ME = 4; Rs_ID = 4;
      step("rst_mdu_c2", 9'b1_0_0_0_01_00_1);
      #1 reset = 1;
      step("rst_async", 9'b0_0_0_0_00_00_0);
      @(negedge clk); clear_in(); reset = 0;
      step("rst_release", 9'b0_0_0_0_00_00_0);
      @(negedge clk);
      step("rst_idle", 9'b0_0_0_0_00_00_0);

      // Statistics scenario: 1 load-use + 1 MDU op + 2 taken branches.
      @(negedge clk); set_load_use();
      step("st_loaduse", 9'b0_1_0_1_00_00_0);
      @(negedge clk); clear_in(); MduStart_EX = 1;
      step("st_mdu1", 9'b1_0_0_0_00_00_0);
      @(negedge clk); clear_in();
      step("st_mdu2", 9'b1_0_0_0_00_00_1);
      @(negedge clk);
      step("st_mdu3", 9'b1_0_0_0_00_00_1);
      @(negedge clk);
      step("st_mdu4", 9'b1_0_0_0_00_00_1);
      @(negedge clk); BranchTaken_EX = 1;
      step("st_br1", 9'b0_0_1_1_00_00_0);
      @(negedge clk); BranchTaken_EX = 0;
      step("st_gap", 9'b0_0_0_0_00_00_0);
      @(negedge clk); BranchTaken_EX = 1;
      step("st_br2", 9'b0_0_1_1_00_00_0);
      @(negedge clk); clear_in();
      step("st_end", 9'b0_0_0_0_00_00_0);
`ifdef HAZARD_STATS_EN
      cnt_check("stall_cnt", StallCnt, 16'd5);
      cnt_check("flush_cnt", FlushCnt, 16'd2);
      reset = 1;
      #1;
      cnt_check("stall_cnt_reset", StallCnt, 16'd0);
      cnt_check("flush_cnt_reset", FlushCnt, 16'd0);
      reset = 0;
`endif

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
